// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int clk_divisor = 1000000,
    parameter int tx_num_bits = 8,
    parameter int parity      = 0
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data_in,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data
);
    localparam int FRAME_CYCLES = clk_divisor * (tx_num_bits + 2 + ((parity != 0) ? 1 : 0));
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_owner;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
`ifdef UART_TX_ARB_RR_EN
    logic [IW-1:0]        r_ptr;
`endif
    logic [IW-1:0]        w_idx;
    logic [IW-1:0]        w_winner;

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = r_busy;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

    // Winner: scan candidates from last to first so the first pending one in search order survives
    always_comb begin
        w_idx    = '0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef UART_TX_ARB_RR_EN
            w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
`else
            w_idx = IW'(k);
`endif
            if (req[w_idx]) w_winner = w_idx;
        end
    end

    // Arbitration FSM: grant in IDLE, hold the channel for one frame time in WAIT
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
`ifdef UART_TX_ARB_RR_EN
            r_ptr      <= '0;
`endif
        end else begin
            r_grant    <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            if (r_state == S_IDLE) begin
                if (|req) begin
                    r_grant    <= NUM_REQ'(1) << w_winner;
                    r_tx_start <= 1'b1;
                    r_tx_data  <= data_in[{w_winner, 3'b000} +: 8];
                    r_busy     <= 1'b1;
                    r_owner    <= w_winner;
                    r_cnt      <= CW'(FRAME_CYCLES - 1);
                    r_state    <= S_WAIT;
                end
            end else if (r_cnt == '0) begin
                r_done  <= NUM_REQ'(1) << r_owner;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
`ifdef UART_TX_ARB_RR_EN
                r_ptr   <= IW'((int'(r_owner) + 1) % NUM_REQ);
`endif
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized, self-checking bench for uart_tx_arbiter (works with or without UART_TX_ARB_RR_EN)
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  grant, done;
    logic        busy, tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  req_p = '0;
    logic [31:0] data_p = '0;
    logic [3:0]  grant_p, done_p;
    logic        busy_p, tx_start_p;
    logic [7:0]  tx_data_p;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mptr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_arbiter #(.NUM_REQ(4), .clk_divisor(4), .tx_num_bits(8), .parity(0)) dut (
        .clk(clk), .RST(RST), .req(req), .data_in(data_in), .grant(grant), .done(done),
        .busy(busy), .tx_start(tx_start), .tx_data(tx_data));

    uart_tx_arbiter #(.NUM_REQ(4), .clk_divisor(4), .tx_num_bits(8), .parity(1)) u_par (
        .clk(clk), .RST(RST), .req(req_p), .data_in(data_p), .grant(grant_p), .done(done_p),
        .busy(busy_p), .tx_start(tx_start_p), .tx_data(tx_data_p));

    // Reference rule: rotate the request vector by the pointer and take its lowest set bit
    function automatic int pick(input logic [3:0] r, input int p);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {r, r} >> p;
        rot = dbl[3:0];
        return (p + $clog2(int'(rot & (~rot + 4'd1)))) % 4;
    endfunction

    function automatic int next_ptr(input int w, input int p);
`ifdef UART_TX_ARB_RR_EN
        return (w + 1) % 4;
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; req = '0; req_p = '0;
        tick(); tick();
        RST = 1'b0; mptr = 0;
    endtask

    // Runs from the tx_start cycle to the done cycle; counts anything that disturbs the frame
    task automatic wait_done(input logic [3:0] req_after, input int at, output int n,
                             output logic [3:0] d, output int extra);
        logic [7:0] td;
        td = tx_data; n = 0; d = '0; extra = 0;
        while (n < 200) begin
            tick(); n++;
            if (n == at) req = req_after;
            if (done != 0) begin d = done; break; end
            if (!busy || grant != 0 || tx_start || tx_data != td) extra++;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; req = 4'b1111; data_in = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({grant, done, busy, tx_start, tx_data} !== 18'd0) begin
                errors++; $display("FAIL reset_outputs: got %b/%b/%b/%b/%h expected all zero", grant, done, busy, tx_start, tx_data);
            end
        end
        RST = 1'b0; mptr = 0;
        tick();
        checks++;
        if (grant !== 4'b0001 || tx_start !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant: got grant=%b start=%b expected 0001/1", grant, tx_start);
        end
        checks++;
        if (tx_data !== data_in[7:0]) begin
            errors++; $display("FAIL reset_first_data: got %h expected %h", tx_data, data_in[7:0]);
        end
    endtask

    task automatic test_single();
        int n, extra;
        logic [3:0] d;
        do_reset();
        req = 4'b0010; data_in = $urandom; data_in[15:8] = 8'h5A;
        tick();
        checks++;
        if (grant !== 4'b0010 || tx_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: got grant=%b start=%b busy=%b expected 0010/1/1", grant, tx_start, busy);
        end
        checks++;
        if (tx_data !== 8'h5A) begin
            errors++; $display("FAIL single_data: got %h expected 5a", tx_data);
        end
        req = '0;
        wait_done(4'b0000, 1, n, d, extra);
        checks++;
        if (d !== 4'b0010 || n != 40) begin
            errors++; $display("FAIL single_done: got done=%b after %0d cycles expected 0010 after 40", d, n);
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_busy: got %0d disturbed cycles, busy at done=%b expected 0/0", extra, busy);
        end
        tick();
        checks++;
        if (done !== 4'b0000 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL single_after: got done=%b data=%h expected 0000/5a", done, tx_data);
        end
    endtask

    task automatic test_contention();
        int n, extra, w, last;
        logic [3:0] d;
        do_reset();
        req = 4'b1111; data_in = $urandom; last = 0;
        tick();
        for (int r = 0; r < 5; r++) begin
            w = pick(4'b1111, mptr);
            checks++;
            if (grant !== 4'(1 << w) || tx_data !== data_in[8*w +: 8]) begin
                errors++; $display("FAIL contention_grant%0d: got %b/%h expected %b/%h", r, grant, tx_data, 4'(1 << w), data_in[8*w +: 8]);
            end
            if (r > 0) begin
                checks++;
                if (cyc - last != 41) begin
                    errors++; $display("FAIL contention_spacing%0d: got %0d expected 41", r, cyc - last);
                end
            end
            last = cyc;
            req[w] = 1'b0;
            wait_done(4'b1111, 1, n, d, extra);
            checks++;
            if (d !== 4'(1 << w) || n != 40 || extra != 0) begin
                errors++; $display("FAIL contention_done%0d: got %b at %0d extra=%0d expected %b at 40 extra=0", r, d, n, extra, 4'(1 << w));
            end
            mptr = next_ptr(w, mptr);
            tick();
        end
        req = '0;
    endtask

    task automatic test_holdoff();
        int n, extra;
        logic [3:0] d;
        do_reset();
        req = 4'b0001; data_in = $urandom;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL holdoff_first: got %b expected 0001", grant);
        end
        req = '0;
        wait_done(4'b0100, 10, n, d, extra);
        checks++;
        if (d !== 4'b0001 || extra != 0) begin
            errors++; $display("FAIL holdoff_wait: got done=%b extra=%0d expected 0001/0", d, extra);
        end
        mptr = next_ptr(0, mptr);
        tick();
        checks++;
        if (grant !== 4'b0100 || tx_data !== data_in[23:16]) begin
            errors++; $display("FAIL holdoff_grant: got %b/%h expected 0100/%h", grant, tx_data, data_in[23:16]);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        int n, extra, seen;
        logic [3:0] d;
        do_reset();
        req = 4'b0001; data_in = $urandom;
        tick();
        req = '0;
        wait_done(4'b0000, 1, n, d, extra);
        mptr = next_ptr(0, mptr);
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            errors++; $display("FAIL resetmid_grant: got %b expected 0010", grant);
        end
        req = '0;
        repeat (19) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; mptr = 0;
        checks++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            errors++; $display("FAIL resetmid_abort: got busy=%b done=%b expected 0/0000", busy, done);
        end
        seen = 0;
        repeat (45) begin
            tick();
            if (done != 0 || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL resetmid_nodone: got %0d active cycles expected 0", seen);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL resetmid_regrant: got %b expected 0001", grant);
        end
        req = '0;
    endtask

    task automatic test_parity();
        int n, w;
        do_reset();
        w = $urandom_range(0, 3);
        req_p = 4'(1 << w); data_p = $urandom;
        tick();
        checks++;
        if (grant_p !== 4'(1 << w) || tx_start_p !== 1'b1 || tx_data_p !== data_p[8*w +: 8]) begin
            errors++; $display("FAIL parity_grant: got %b/%b/%h expected %b/1/%h", grant_p, tx_start_p, tx_data_p, 4'(1 << w), data_p[8*w +: 8]);
        end
        req_p = '0; n = 0;
        while (n < 200) begin
            tick(); n++;
            if (done_p != 0) break;
        end
        checks++;
        if (n != 44 || done_p !== 4'(1 << w)) begin
            errors++; $display("FAIL parity_done: got %b after %0d cycles expected %b after 44", done_p, n, 4'(1 << w));
        end
    endtask

    task automatic test_random();
        int n, extra, w;
        logic [3:0] d, nxt;
        do_reset();
        for (int it = 0; it < 25; it++) begin
            req = req | ($urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0);
            data_in = $urandom;
            tick();
            if (req == 0) begin
                checks++;
                if (grant !== 4'b0000 || busy !== 1'b0) begin
                    errors++; $display("FAIL random_idle%0d: got grant=%b busy=%b expected 0000/0", it, grant, busy);
                end
            end else begin
                w = pick(req, mptr);
                checks++;
                if (grant !== 4'(1 << w) || tx_data !== data_in[8*w +: 8]) begin
                    errors++; $display("FAIL random_grant%0d: req=%b got %b/%h expected %b/%h", it, req, grant, tx_data, 4'(1 << w), data_in[8*w +: 8]);
                end
                nxt = (req & ~4'(1 << w)) | 4'($urandom_range(0, 15));
                req = req & ~4'(1 << w);
                wait_done(nxt, $urandom_range(1, 39), n, d, extra);
                checks++;
                if (d !== 4'(1 << w) || n != 40 || extra != 0) begin
                    errors++; $display("FAIL random_done%0d: got %b at %0d extra=%0d expected %b at 40 extra=0", it, d, n, extra, 4'(1 << w));
                end
                mptr = next_ptr(w, mptr);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_holdoff();
        test_reset_mid();
        test_parity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `NUM_REQ` byte producers. The block sits between the requesters and `tx_fsm`, in place of the debounced one-shot start path. It selects one pending request, launches a single frame with a one-cycle start pulse and the byte, and holds off all other requesters for the computed frame duration. It then reports completion to the owner and arbitrates again.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, at least 2.
- `clk_divisor`, 1000000: clock cycles per UART bit. Must match `tx_fsm`.
- `tx_num_bits`, 8: data bits per frame, 1..8. Must match `tx_fsm`.
- `parity`, 0: nonzero means the frame carries a parity bit. Must match `tx_fsm`.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request, one bit per requester.
- `data_in`  in  NUM_REQ*8  byte for requester i is at `data_in[8*i+7:8*i]`.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse: the request was accepted and the data was sampled.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse: the owner's frame time has elapsed.
- `busy`  out  1  high while a frame is owned.
- `tx_start`  out  1  one-cycle start pulse to `tx_fsm`.
- `tx_data`  out  8  byte to `tx_fsm`, held stable for the whole frame.

## Operation
- FRAME_CYCLES = `clk_divisor` * (`tx_num_bits` + 2 + (`parity` != 0)). This counts start bit, data bits, optional parity bit and stop bit.
- The counter width is $clog2(FRAME_CYCLES). The counter is unsigned, counts down and never wraps.
- State IDLE:
  - If `req` is zero, stay in IDLE.
  - Otherwise select winner w.
  - Register `grant` = 1<<w, `tx_start` = 1, `tx_data` = data_in[w], `busy` = 1, owner = w, cnt = FRAME_CYCLES-1.
  - Go to WAIT.
- State WAIT:
  - `grant` and `tx_start` return to 0.
  - cnt decrements once per cycle.
  - On the edge where cnt == 0: `done` = 1<<owner, `busy` = 0, update the round-robin pointer if compiled in, and go to IDLE.
- Request semantics:
  - `req` is a level signal, sampled only in IDLE.
  - A requester holds `req` and its data until it sees `grant`, then drops `req` within one cycle or it re-enters arbitration.
  - Requests raised during WAIT are held off. No request is lost while `req` stays high.
- `tx_data` keeps its value in IDLE. It is not cleared until the next grant or reset.
- Requesters never receive simultaneous grants. Exactly one `grant` bit is set per arbitration.
- Reset mid-frame:
  - Return to IDLE; clear cnt, owner and pointer.
  - No `done` is issued for the aborted frame.
  - `tx_fsm` shares the reset, so the frame is abandoned.

## Timing
- Reset values: `grant` = 0, `done` = 0, `busy` = 0, `tx_start` = 0, `tx_data` = 0x00. State = IDLE, pointer = 0.
- Latency from a `req` seen in IDLE at edge E to `grant`/`tx_start`: outputs are high in the cycle after E (1 cycle).
- `done` is high FRAME_CYCLES cycles after the `tx_start` cycle.
- Back-to-back frames: successive `tx_start` pulses are exactly FRAME_CYCLES+1 cycles apart. This includes one IDLE cycle as a guard for `tx_fsm`.
- `busy` rises with `tx_start` and falls with `done`.

## Configuration
- `UART_TX_ARB_RR_EN` defined:
  - Round-robin arbitration. Search begins at (last winner + 1) mod NUM_REQ.
  - The pointer updates when `done` is issued.
- `UART_TX_ARB_RR_EN` undefined:
  - Fixed priority: the lowest set index wins.
  - No pointer register exists.

## Test plan
Common setup: `clk_divisor`=4, `tx_num_bits`=8, `parity`=0, FRAME_CYCLES=40, NUM_REQ=4.
- Reset: hold `RST` for 3 cycles with `req`=4'b1111 -> all outputs 0 throughout; the first `grant` appears 1 cycle after `RST` falls.
- Single request: `req`=4'b0010, requester 1 byte=0x5A -> next cycle `grant`=4'b0010, `tx_start`=1, `tx_data`=0x5A; `done`=4'b0010 exactly 40 cycles after `tx_start`; `busy` high for those 40 cycles.
- Contention, `req`=4'b1111 held, dropping each bit for one cycle after its grant:
  - With RR: grants in order 0,1,2,3,0.
  - Without RR: index 0 granted each round.
  - Either mode: `tx_start` spacing is 41 cycles.
- Hold-off: raise `req[2]` 10 cycles into requester 0's frame -> no grant during WAIT; `grant`=4'b0100 one cycle after `done`=4'b0001.
- Reset mid-frame: assert `RST` at cycle 20 of the frame -> `busy`=0 next cycle, no `done` pulse; after release, `req`=4'b1001 -> `grant`=4'b0001.
- Parity frame: set `parity`=1 -> `done` exactly 44 cycles after `tx_start`.
